// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory responder for the multi-cycle RV32I control unit.
// Captures one MEM-stage request, waits WAIT_CYCLES, performs a byte/half/word
// store or a sign/zero-extended load on an internal word array, then pulses dm_valid.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   DM_read_en/write_en  level request enables (held by the control unit)
//   load_store_op        000 LW, 100 LB, 101 LH, 110 LBU, 111 LHU, 001 SB, 010 SH, 011 SW
//   addr, wdata          byte address and store data
//   rdata                extended load result (held across stores)
//   dm_valid             one-cycle completion pulse
//   dm_busy              high from request capture through RESP
//   dm_err               illegal request flag, qualified by dm_valid
module dmem_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             DM_read_en,
    input  logic             DM_write_en,
    input  logic [2:0]       load_store_op,
    input  logic [31:0]      addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             dm_valid,
    output logic             dm_busy,
    output logic             dm_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t             state_q, state_d;
    logic               armed_q, armed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rd_q, rd_d, wr_q, wr_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   mem [DEPTH_WORDS];
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   rword;
    logic [WIDTH-1:0]   wword;
    logic               mem_we;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [WIDTH-1:0]   load_val;
    logic               is_ld_op, is_half, is_word, illegal;

    assign idx   = addr_q[IDX_W+1:2];
    assign rword = mem[idx];

    // Legality of the captured request; out-of-range means any address bit above the array is set.
    always_comb begin
        is_ld_op = (op_q == 3'b000) || op_q[2];
        is_half  = (op_q == 3'b101) || (op_q == 3'b111) || (op_q == 3'b010);
        is_word  = (op_q == 3'b000) || (op_q == 3'b011);
        illegal  = (rd_q && wr_q)
                 || (rd_q && !is_ld_op)
                 || (wr_q && is_ld_op)
                 || (is_half && addr_q[0])
                 || (is_word && (addr_q[1:0] != 2'b00))
                 || (addr_q[31:IDX_W+2] != '0);
    end

    // Lane selection, load extension and store merge.
    always_comb begin
        byte_sel = rword[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? rword[31:16] : rword[15:0];
        case (op_q)
            3'b100:  load_val = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b110:  load_val = {(WIDTH-8)'(0), byte_sel};
            3'b101:  load_val = {{(WIDTH-16){half_sel[15]}}, half_sel};
            3'b111:  load_val = {(WIDTH-16)'(0), half_sel};
            default: load_val = rword;
        endcase
        wword = rword;
        case (op_q)
            3'b001:  wword[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            3'b010:  wword[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            3'b011:  wword = wdata_q;
            default: wword = rword;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q | (!DM_read_en && !DM_write_en);
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && (DM_read_en || DM_write_en)) begin
                    rd_d    = DM_read_en;
                    wr_d    = DM_write_en;
                    op_d    = load_store_op;
                    addr_d  = addr;
                    wdata_d = wdata;
                    busy_d  = 1'b1;
                    armed_d = 1'b0;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                valid_d = 1'b1;
                err_d   = illegal;
                state_d = RESP;
                if (illegal) begin
                    rdata_d = '0;
                end else if (rd_q) begin
                    rdata_d = load_val;
                end else begin
                    mem_we = 1'b1;
                end
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Word array is not reset; a reset coinciding with the ACCESS edge blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[idx] <= wword;
        end
    end

    assign rdata    = rdata_q;
    assign dm_valid = valid_q;
    assign dm_busy  = busy_q;
    assign dm_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic [31:0] rdata1, rdata0;
    logic        valid1, busy1, err1;
    logic        valid0, busy0, err0;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [2:0] LW = 3'b000, LB = 3'b100, LH = 3'b101, LBU = 3'b110,
                           LHU = 3'b111, SB = 3'b001, SH = 3'b010, SW = 3'b011;

    always #5 clk = ~clk;

    dmem_ctrl #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .DM_read_en(rd_en), .DM_write_en(wr_en),
        .load_store_op(op), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .dm_valid(valid1), .dm_busy(busy1), .dm_err(err1)
    );

    dmem_ctrl #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .DM_read_en(rd_en), .DM_write_en(wr_en),
        .load_store_op(op), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .dm_valid(valid0), .dm_busy(busy0), .dm_err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on both instances; expects dm_valid 2 edges after capture (WAIT=1)
    // and 1 edge after capture (WAIT=0), then drops enables for one re-arm cycle.
    task automatic do_req(input string tag, input logic r, input logic w, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] wd, input logic exp_err,
                          input logic chk_rd, input logic [31:0] exp_rd);
        int n;
        int lat0;
        logic [31:0] r0;
        logic e0;
        rd_en = r; wr_en = w; op = o; addr = a; wdata = wd;
        @(posedge clk); #1;
        chk({tag, ":busy"}, 32'(busy1), 32'd1);
        n = 0; lat0 = -1; r0 = '0; e0 = 1'b0;
        while (!valid1 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (valid0 && lat0 < 0) begin
                lat0 = n; r0 = rdata0; e0 = err0;
            end
        end
        chk({tag, ":lat1"}, 32'(n), 32'd2);
        chk({tag, ":lat0"}, 32'(lat0), 32'd1);
        chk({tag, ":err1"}, 32'(err1), 32'(exp_err));
        chk({tag, ":err0"}, 32'(e0), 32'(exp_err));
        if (chk_rd) begin
            chk({tag, ":rdata1"}, rdata1, exp_rd);
            chk({tag, ":rdata0"}, r0, exp_rd);
        end
        rd_en = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
        chk({tag, ":idle"}, {30'd0, busy1, valid1}, 32'd0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; op = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {rdata1[29:0], valid1, busy1}, 32'd0);
        chk("reset_err", {31'd0, err1}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic word store / load
        do_req("sw10",  1'b0, 1'b1, SW, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, '0);
        do_req("lw10",  1'b1, 1'b0, LW, 32'h10, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
        // byte lane store and byte loads
        do_req("sw10b", 1'b0, 1'b1, SW, 32'h10, 32'h11223344, 1'b0, 1'b0, '0);
        do_req("sb11",  1'b0, 1'b1, SB, 32'h11, 32'h000000A5, 1'b0, 1'b0, '0);
        do_req("lw10c", 1'b1, 1'b0, LW, 32'h10, 32'h0,        1'b0, 1'b1, 32'h1122A544);
        do_req("lb11",  1'b1, 1'b0, LB, 32'h11, 32'h0,        1'b0, 1'b1, 32'hFFFFFFA5);
        do_req("lbu11", 1'b1, 1'b0, LBU, 32'h11, 32'h0,       1'b0, 1'b1, 32'h000000A5);
        // halfword store and halfword loads
        do_req("sw20",  1'b0, 1'b1, SW, 32'h20, 32'h0,        1'b0, 1'b0, '0);
        do_req("sh22",  1'b0, 1'b1, SH, 32'h22, 32'h00008001, 1'b0, 1'b0, '0);
        do_req("lh22",  1'b1, 1'b0, LH, 32'h22, 32'h0,        1'b0, 1'b1, 32'hFFFF8001);
        do_req("lhu22", 1'b1, 1'b0, LHU, 32'h22, 32'h0,       1'b0, 1'b1, 32'h00008001);
        do_req("lw20",  1'b1, 1'b0, LW, 32'h20, 32'h0,        1'b0, 1'b1, 32'h80010000);
        // illegal requests: err, rdata 0, memory untouched
        do_req("lw13",  1'b1, 1'b0, LW, 32'h13, 32'h0,        1'b1, 1'b1, 32'h0);
        do_req("lw20a", 1'b1, 1'b0, LW, 32'h20, 32'h0,        1'b0, 1'b1, 32'h80010000);
        do_req("sh21",  1'b0, 1'b1, SH, 32'h21, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
        do_req("lw20b", 1'b1, 1'b0, LW, 32'h20, 32'h0,        1'b0, 1'b1, 32'h80010000);
        do_req("wr_ld", 1'b0, 1'b1, LW, 32'h20, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
        do_req("lw20c", 1'b1, 1'b0, LW, 32'h20, 32'h0,        1'b0, 1'b1, 32'h80010000);
        do_req("both",  1'b1, 1'b1, SW, 32'h20, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
        do_req("lw20d", 1'b1, 1'b0, LW, 32'h20, 32'h0,        1'b0, 1'b1, 32'h80010000);
        do_req("sw0",   1'b0, 1'b1, SW, 32'h0,  32'hCAFEF00D, 1'b0, 1'b0, '0);
        do_req("oor",   1'b0, 1'b1, SW, 32'h1000, 32'h12345678, 1'b1, 1'b1, 32'h0);
        do_req("lw0",   1'b1, 1'b0, LW, 32'h0,  32'h0,        1'b0, 1'b1, 32'hCAFEF00D);

        // held enable gives one access only
        rd_en = 1'b0; wr_en = 1'b1; op = SW; addr = 32'h30; wdata = 32'h55;
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (valid1) pulses++;
        end
        chk("held_pulses", 32'(pulses), 32'd1);
        wr_en = 1'b0;
        @(posedge clk); #1;
        do_req("rearm", 1'b0, 1'b1, SW, 32'h30, 32'h66,       1'b0, 1'b0, '0);
        do_req("lw30",  1'b1, 1'b0, LW, 32'h30, 32'h0,        1'b0, 1'b1, 32'h66);

        // reset mid-operation aborts the store
        do_req("sw40",  1'b0, 1'b1, SW, 32'h40, 32'h12345678, 1'b0, 1'b0, '0);
        do_req("lw30b", 1'b1, 1'b0, LW, 32'h30, 32'h0,        1'b0, 1'b1, 32'h66);
        rd_en = 1'b0; wr_en = 1'b1; op = SW; addr = 32'h40; wdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy1), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        chk("abort_outs1", {rdata1[29:0], valid1, busy1}, 32'd0);
        chk("abort_outs0", {rdata0[29:0], valid0, busy0}, 32'd0);
        chk("abort_err", {30'd0, err1, err0}, 32'd0);
        @(posedge clk); #1;
        do_req("lw40",  1'b1, 1'b0, LW, 32'h40, 32'h0,        1'b0, 1'b1, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory responder for the multi-cycle RV32I control unit. Serves the MEM-stage request: DM_read_en / DM_write_en, the 3-bit load_store_op code and the ALU-computed byte address.
- Performs byte/half/word stores with byte lanes, and sign/zero-extended loads, against an internal word array.
- Finishes each access with a one-cycle dm_valid pulse.
- Has a configurable wait-state counter to model slow memory, and flags illegal requests.

Parameters:
- WIDTH, 32, data width (fixed at 32 for RV32I lane logic)
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two
- WAIT_CYCLES, 1, extra wait states between request capture and array access (0..15)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- DM_read_en  input  1  load request (level)
- DM_write_en  input  1  store request (level)
- load_store_op  input  3  000 LW, 100 LB, 101 LH, 110 LBU, 111 LHU, 001 SB, 010 SH, 011 SW
- addr  input  32  byte address
- wdata  input  32  store data (low bytes used for SB/SH)
- rdata  output  32  extended load result
- dm_valid  output  1  one-cycle completion pulse
- dm_busy  output  1  high from request capture until the end of RESP
- dm_err  output  1  qualified by dm_valid; request was illegal, no array access done

Behaviour:
- Reset values: rdata=0, dm_valid=0, dm_busy=0, dm_err=0, state=IDLE, armed=1, wait counter=0. The memory array is NOT cleared by reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - If armed and (DM_read_en | DM_write_en), capture op, addr and wdata at the edge.
  - At the same edge: set dm_busy=1, clear armed, load counter=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else to ACCESS.
- WAIT: decrement the counter each cycle; go to ACCESS when it reaches 1 (exactly WAIT_CYCLES cycles in WAIT).
- ACCESS (one cycle): check legality using the captured values, then:
  - Legal store: update the addressed word with byte enables.
    - SB writes lane addr[1:0] with wdata[7:0].
    - SH writes lanes {addr[1],0}/{addr[1],1} with wdata[15:0].
    - SW writes all lanes.
  - Legal load: select the lane(s) the same way and extend.
    - LB/LH sign-extend from bit 7/15.
    - LBU/LHU zero-extend.
    - LW passes the word through.
  - Go to RESP.
- RESP (one cycle):
  - dm_valid=1 and dm_err valid.
  - rdata updated for loads: the result, or 0 on error. rdata is held for stores.
  - dm_busy=0 from the next cycle; return to IDLE.
- Latency: dm_valid is high in cycle WAIT_CYCLES+2 after the capture edge (WAIT_CYCLES=1 gives 3 cycles).
- Re-arm rule: armed is set when both enables are sampled low. The control unit holds its enable across states, so a held enable must never start a second access. Each new request needs one low cycle first.
- Illegal request (dm_err=1, no array write, rdata=0):
  - Both enables high at capture.
  - Read with a store code (001/010/011), or write with a load code (000/1xx).
  - Halfword with addr[0]=1, or word with addr[1:0]!=0.
  - addr >= 4*DEPTH_WORDS.
- Word index is addr[2 +: log2(DEPTH_WORDS)].
- Inputs are ignored while dm_busy; captured values are used throughout.
- Reset mid-operation:
  - Reset in IDLE/WAIT aborts with no array write.
  - Reset asserted at the ACCESS edge also suppresses the write.
  - All outputs return to reset values the next cycle.

Test Plan:
- WAIT_CYCLES=1: SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 → dm_valid 3 cycles after each capture, rdata=0xDEADBEEF, dm_err=0.
- SB addr=0x11 wdata=0x000000A5 over word 0x11223344 → LW reads 0x1122A544. LB addr=0x11 → 0xFFFFFFA5. LBU addr=0x11 → 0x000000A5.
- SH addr=0x22 wdata=0x8001 over word 0 → LH addr=0x22 reads 0xFFFF8001. LHU addr=0x22 reads 0x00008001.
- Illegal requests each give dm_valid with dm_err=1, rdata=0 and memory unchanged (a follow-up LW confirms):
  - LW addr=0x13
  - SH addr=0x21
  - write with op=000
  - both enables high
  - addr=4*DEPTH_WORDS
- Hold DM_write_en high for 10 cycles → exactly one dm_valid pulse. Drop the enable for 1 cycle and reassert → a second access occurs.
- Start SW to 0x40; assert rst during WAIT → no write (LW 0x40 returns the old value), outputs at reset values. With WAIT_CYCLES=0, latency is 2 cycles.
